pwm_capture: RTL
================

# pwm_capture

Measures an incoming PWM waveform, such as one looped back from a PMOD pin, and reports its high time and period in i_Clk cycles. It is the receiving end of the team's PWM generator and is used to close the loop on generated duty and period settings. Each complete period produces one o_Valid pulse. Stuck-high and stuck-low inputs are flagged through a timeout.

## Interface
- CNT_W, 16: width of the measurement counters and of o_High and o_Period.
- TIMEOUT, 65535: cycles without a rising edge before a stuck flag is raised. Legal range is 2 to 2^CNT_W−1.
- FILT_LEN, 3: number of consecutive identical samples needed to accept a level change. Used only when the glitch filter is compiled in.

- i_Clk, input, 1: the single clock.
- i_Reset, input, 1: synchronous, active-high reset.
- i_PWM, input, 1: asynchronous PWM input.
- o_High, output, CNT_W: high time of the last complete period, in cycles.
- o_Period, output, CNT_W: length of the last complete period, in cycles.
- o_Valid, output, 1: one-cycle pulse when o_High and o_Period update.
- o_Stuck_High, output, 1: input held high for TIMEOUT cycles. Sticky until the next rising edge.
- o_Stuck_Low, output, 1: input held low for TIMEOUT cycles. Sticky until the next rising edge.
- o_Level, output, 1: synchronized (and filtered, when enabled) input level.

## Operation
- **Synchronizer:** two-flop synchronizer on i_PWM gives `lvl`. The `prev` register holds `lvl` from the previous cycle.
- **Edges:** `rise` = lvl & ~prev. `fall` = ~lvl & prev.
- **Counters:** `per_cnt` and `hi_cnt` are CNT_W bits wide and saturate at all-ones. `hi_lat` holds the latched high time.
- **FSM states:** IDLE, HIGH, LOW.
  - IDLE: on `rise`, load per_cnt=1 and hi_cnt=1, then go to HIGH. No o_Valid is produced on this edge.
  - HIGH: per_cnt++ and hi_cnt++ each cycle. On `fall`, load hi_lat ← hi_cnt, per_cnt++, and go to LOW.
  - LOW: per_cnt++ each cycle. On `rise`, set o_Period ← per_cnt, o_High ← hi_lat, and o_Valid=1 for one cycle. Then reload per_cnt=1 and hi_cnt=1 and go to HIGH.
- **Result:** a waveform that is high for H cycles and low for L cycles reports o_High=H and o_Period=H+L.
- **Timeout:** in HIGH or LOW, if per_cnt==TIMEOUT and there is no `rise` in that cycle:
  - In HIGH, set o_Stuck_High. In LOW, set o_Stuck_Low.
  - Go to IDLE and do not assert o_Valid.
  - o_High and o_Period keep their previous values.
- **Rise and timeout in the same cycle:** `rise` wins. The period is reported as TIMEOUT and no stuck flag is set.
- **Any `rise`** clears both stuck flags.
- **First period after reset or timeout:** the first rise only arms the FSM, so the first o_Valid follows the second rise.
- **Reset values:** o_High=0, o_Period=0, o_Valid=0, o_Stuck_High=0, o_Stuck_Low=0, o_Level=0. The FSM returns to IDLE and sync, prev and filter state clear to 0.
- **Reset mid-period:** the partial measurement is discarded. If i_PWM is high when reset releases, a `rise` is seen after sync latency and only arms the FSM.

## Timing
- **Filter disabled:** i_PWM is sampled high at clock edge k. Then `lvl`=1 after edge k+1, `rise` is true in the following cycle, and o_Valid, o_High and o_Period update at edge k+2.
- **Filter enabled:** add FILT_LEN cycles of latency to every edge.
- **Throughput:** one measurement per input period. The minimum period is 2 cycles post-filter (H≥1, L≥1).
- **o_Valid** is never high in two consecutive cycles unless the period is 1, and a period of 1 is not possible.
- **Stuck flags** assert at the clock edge following the cycle where per_cnt==TIMEOUT.

## Configuration
- **PWM_CAPTURE_GLITCH_FILTER_EN defined:** a counter between the synchronizer and `lvl` accepts a new level only after FILT_LEN consecutive samples agree with it. Pulses shorter than FILT_LEN cycles are ignored entirely.
- **Not defined:** `lvl` is the second synchronizer flop directly, and FILT_LEN is unused.

## Test plan
- **Basic measurement:** reset, then drive H=10, L=30 repeatedly. Required: the first o_Valid comes after the second rise, with o_High=10 and o_Period=40, then one o_Valid every 40 cycles.
- **Duty change:** switch from H=10, L=30 to H=35, L=5. Required: the next complete period reports o_High=35 and o_Period=40 with no intermediate bad value.
- **Stuck high:** TIMEOUT=100. Go high after a valid period and hold. Required: o_Stuck_High=1 exactly 100 cycles after the rise and o_Valid stays low. The next rise clears the flag, and the period after that reports correctly.
- **Stuck low and boundary:** hold low and check o_Stuck_Low. Separately, drive a period of exactly 100 with TIMEOUT=100. Required: o_Period=100 and no flag.
- **Mid-period reset:** assert i_Reset for 1 cycle in the middle of HIGH. Required: all outputs are 0 the next cycle, and no o_Valid until two rises later.
- **Glitch filter (macro on, FILT_LEN=3):** inject 2-cycle low glitches inside a H=20, L=20 wave. Required: o_High=20, o_Period=40 and no extra o_Valid. With the macro off, the same stimulus produces extra o_Valid pulses.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM input capture: reports high time and period of each complete input cycle, with
// stuck-high/stuck-low timeout flags. Define PWM_CAPTURE_GLITCH_FILTER_EN to add a glitch filter.
module pwm_capture #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TIMEOUT  = 65535,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_PWM,
  output logic [CNT_W-1:0] o_High,
  output logic [CNT_W-1:0] o_Period,
  output logic             o_Valid,
  output logic             o_Stuck_High,
  output logic             o_Stuck_Low,
  output logic             o_Level
);

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic             lvl, rise, fall, timeout;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d, hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] high_q, high_d, period_q, period_d;
  logic             valid_q, valid_d, stuck_hi_q, stuck_hi_d, stuck_lo_q, stuck_lo_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_PWM;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int unsigned FiltW = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;

  logic [FiltW-1:0] filt_cnt_q;
  logic             lvl_q;

  // A new level is taken only after FILT_LEN consecutive disagreeing samples.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      filt_cnt_q <= '0;
      lvl_q      <= 1'b0;
    end else if (sync2_q == lvl_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q == FiltW'(FILT_LEN - 1)) begin
      lvl_q      <= sync2_q;
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + 1'b1;
    end
  end

  assign lvl = lvl_q;
`else
  // FILT_LEN only matters when the filter is built in.
  if (FILT_LEN == 0) begin : g_filt_len_unused
  end

  assign lvl = sync2_q;
`endif

  assign rise    = lvl & ~prev_q;
  assign fall    = ~lvl & prev_q;
  assign timeout = (per_cnt_q == TimeoutVal);

  always_comb begin
    state_d    = state_q;
    per_cnt_d  = per_cnt_q;
    hi_cnt_d   = hi_cnt_q;
    hi_lat_d   = hi_lat_q;
    high_d     = high_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    stuck_hi_d = stuck_hi_q & ~rise;
    stuck_lo_d = stuck_lo_q & ~rise;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          per_cnt_d = CNT_W'(1);
          hi_cnt_d  = CNT_W'(1);
          state_d   = StHigh;
        end
      end
      StHigh: begin
        if (timeout && !rise) begin
          stuck_hi_d = 1'b1;
          state_d    = StIdle;
        end else begin
          per_cnt_d = sat_inc(per_cnt_q);
          hi_cnt_d  = sat_inc(hi_cnt_q);
          if (fall) begin
            hi_lat_d = hi_cnt_q;
            state_d  = StLow;
          end
        end
      end
      StLow: begin
        // A rise in the timeout cycle still completes the period.
        if (rise) begin
          period_d  = per_cnt_q;
          high_d    = hi_lat_q;
          valid_d   = 1'b1;
          per_cnt_d = CNT_W'(1);
          hi_cnt_d  = CNT_W'(1);
          state_d   = StHigh;
        end else if (timeout) begin
          stuck_lo_d = 1'b1;
          state_d    = StIdle;
        end else begin
          per_cnt_d = sat_inc(per_cnt_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q    <= StIdle;
      prev_q     <= 1'b0;
      per_cnt_q  <= '0;
      hi_cnt_q   <= '0;
      hi_lat_q   <= '0;
      high_q     <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      stuck_hi_q <= 1'b0;
      stuck_lo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= lvl;
      per_cnt_q  <= per_cnt_d;
      hi_cnt_q   <= hi_cnt_d;
      hi_lat_q   <= hi_lat_d;
      high_q     <= high_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      stuck_hi_q <= stuck_hi_d;
      stuck_lo_q <= stuck_lo_d;
    end
  end

  assign o_High       = high_q;
  assign o_Period     = period_q;
  assign o_Valid      = valid_q;
  assign o_Stuck_High = stuck_hi_q;
  assign o_Stuck_Low  = stuck_lo_q;
  assign o_Level      = lvl;

endmodule
